// File: rtl/rs232_pkg.sv
// Shared RS-232 constants, FSM encoding and helpers for the receive and transmit paths.
package rs232_pkg;

   localparam int OS_DEFAULT = 16;
   localparam int DATA_BITS  = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } rs232_state_e;

   // Clocks per oversample tick, rounded to nearest and never below one.
   function automatic int rs232_div(input int clk_hz, input int baud, input int os);
      int d;
      d = (clk_hz + (baud * os) / 2) / (baud * os);
      if (d < 1) begin
         d = 1;
      end else begin
         d = d;
      end
      return d;
   endfunction

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/rs232_baud_tick.sv
// Oversample tick generator: modulo-DIV counter, restartable so a frame aligns to its start edge.
module rs232_baud_tick #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_r;

   assign tick = (cnt_r == CNT_LAST);

   // Free-running divider, forced back to zero on restart.
   always_ff @(posedge clk) begin
      if (rst || restart) begin
         cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + CW'(1);
      end
   end

endmodule

// File: rtl/rs232_rx_deframer.sv
// 8N1 receive deframer: synchronizer, 3-sample majority vote per bit, one-entry valid/ready output.
module rs232_rx_deframer
   import rs232_pkg::*;
#(
   parameter int CLK_HZ = 25_000_000,
   parameter int BAUD   = 115_200,
   parameter int OS     = OS_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       break_det,
   output logic       rx_idle
);

   localparam int DIV  = rs232_div(CLK_HZ, BAUD, OS);
   localparam int OS_W = $clog2(OS);
   localparam int BI_W = $clog2(DATA_BITS);
   localparam logic [OS_W-1:0] CNT_LAST = OS_W'(OS - 1);
   localparam logic [OS_W-1:0] SMP_A    = OS_W'(OS / 2 - 1);
   localparam logic [OS_W-1:0] SMP_B    = OS_W'(OS / 2);
   localparam logic [OS_W-1:0] SMP_C    = OS_W'(OS / 2 + 1);
   localparam logic [BI_W-1:0] BIT_LAST = BI_W'(DATA_BITS - 1);

   logic                 sync1_r;
   logic                 rxs_r;
   rs232_state_e         state_r;
   logic [OS_W-1:0]      os_cnt_r;
   logic [BI_W-1:0]      bit_idx_r;
   logic [DATA_BITS-1:0] shreg_r;
   logic                 smp_a_r;
   logic                 smp_b_r;
   logic [7:0]           data_r;
   logic                 valid_r;
   logic                 frame_err_r;
   logic                 overrun_r;
   logic                 break_r;
   logic                 idle_r;

   logic tick_s;
   logic start_s;
   logic vote_s;
   logic at_vote_s;
   logic at_end_s;
   logic active_s;

   assign start_s   = (state_r == ST_IDLE) && !rxs_r;
   assign active_s  = (state_r == ST_START) || (state_r == ST_DATA) || (state_r == ST_STOP);
   assign vote_s    = maj3(smp_a_r, smp_b_r, rxs_r);
   assign at_vote_s = tick_s && (os_cnt_r == SMP_C);
   assign at_end_s  = tick_s && (os_cnt_r == CNT_LAST);

   rs232_baud_tick #(
      .DIV (DIV)
   ) u_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (start_s),
      .tick    (tick_s)
   );

   // Two-flop synchronizer; idles high so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 1'b1;
         rxs_r   <= 1'b1;
      end else begin
         sync1_r <= rxd;
         rxs_r   <= sync1_r;
      end
   end

   // Frame FSM, bit-phase counter, vote samples and the holding register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         os_cnt_r    <= '0;
         bit_idx_r   <= '0;
         shreg_r     <= '0;
         smp_a_r     <= 1'b1;
         smp_b_r     <= 1'b1;
         data_r      <= 8'h00;
         valid_r     <= 1'b0;
         frame_err_r <= 1'b0;
         overrun_r   <= 1'b0;
         break_r     <= 1'b0;
         idle_r      <= 1'b1;
      end else begin
         frame_err_r <= 1'b0;
         overrun_r   <= 1'b0;
         if (valid_r && rx_ready) begin
            valid_r <= 1'b0;
         end
         if (tick_s && active_s) begin
            os_cnt_r <= (os_cnt_r == CNT_LAST) ? '0 : os_cnt_r + OS_W'(1);
            if (os_cnt_r == SMP_A) begin
               smp_a_r <= rxs_r;
            end
            if (os_cnt_r == SMP_B) begin
               smp_b_r <= rxs_r;
            end
         end
         case (state_r)
            ST_IDLE: begin
               if (!rxs_r) begin
                  state_r  <= ST_START;
                  os_cnt_r <= '0;
                  idle_r   <= 1'b0;
               end
            end
            ST_START: begin
               if (at_vote_s && vote_s) begin
                  state_r <= ST_IDLE;
                  idle_r  <= 1'b1;
               end else if (at_end_s) begin
                  state_r   <= ST_DATA;
                  bit_idx_r <= '0;
               end
            end
            ST_DATA: begin
               if (at_vote_s) begin
                  shreg_r <= {vote_s, shreg_r[DATA_BITS-1:1]};
               end
               if (at_end_s) begin
                  if (bit_idx_r == BIT_LAST) begin
                     state_r <= ST_STOP;
                  end else begin
                     bit_idx_r <= bit_idx_r + BI_W'(1);
                  end
               end
            end
            ST_STOP: begin
               // Decide mid stop bit so a following start edge is never missed.
               if (at_vote_s) begin
                  if (vote_s) begin
                     state_r <= ST_IDLE;
                     idle_r  <= 1'b1;
                     if (!valid_r || rx_ready) begin
                        data_r  <= shreg_r;
                        valid_r <= 1'b1;
                     end else begin
                        overrun_r <= 1'b1;
                     end
                  end else begin
                     frame_err_r <= 1'b1;
                     if (shreg_r == '0) begin
                        state_r <= ST_BREAK;
                        break_r <= 1'b1;
                     end else begin
                        state_r <= ST_IDLE;
                        idle_r  <= 1'b1;
                     end
                  end
               end
            end
            ST_BREAK: begin
               if (rxs_r) begin
                  state_r <= ST_IDLE;
                  break_r <= 1'b0;
                  idle_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               break_r <= 1'b0;
               idle_r  <= 1'b1;
            end
         endcase
      end
   end

   assign rx_data   = data_r;
   assign rx_valid  = valid_r;
   assign frame_err = frame_err_r;
   assign overrun   = overrun_r;
   assign break_det = break_r;
   assign rx_idle   = idle_r;

endmodule

// File: doc/rs232_rx_deframer.md
# rs232_rx_deframer

Receive-side RS-232 deframer for the TinyTapeout RS-232 design. It converts the asynchronous 8N1 serial line arriving on `uio_in[0]` into bytes using a 2-FF synchronizer, 16x oversampling and 3-sample majority voting, and presents each byte on a one-entry valid/ready holding register. It also reports framing errors, overruns and line breaks. It is the counterpart to the existing transmitter and feeds `uo_out` and the status logic in the top level.

## Interface
- `CLK_HZ`, default 25_000_000: system clock frequency.
- `BAUD`, default 115_200: line rate.
- `OS`, default 16: oversample factor; must be even and ≥ 8.
- `DIV`, derived as (CLK_HZ + BAUD*OS/2) / (BAUD*OS): clocks per oversample tick, at least 1.
- `clk`, in, 1: sole clock.
- `rst`, in, 1: synchronous, active-high reset.
- `rxd`, in, 1: raw serial line, idle high, asynchronous to `clk`.
- `rx_data`, out, 8: received byte, LSB first on the wire.
- `rx_valid`, out, 1: `rx_data` holds an unconsumed byte.
- `rx_ready`, in, 1: consumer accepts the byte when `rx_valid && rx_ready`.
- `frame_err`, out, 1: one-cycle pulse when the stop bit is sampled low.
- `overrun`, out, 1: one-cycle pulse when a completed byte is dropped.
- `break_det`, out, 1: level, high while in BREAK.
- `rx_idle`, out, 1: level, high while the FSM is in IDLE.

## Operation
- Synchronizer: 2 flops on `rxd`, both reset to 1. All logic below uses the synchronized value `rxs`.
- Tick generator: a modulo-DIV counter produces a one-cycle `tick`. It is forced to restart at 0 when a start edge is detected, so each frame is phase-aligned to its own start edge.
- Bit-phase counter `os_cnt` counts 0..OS-1 on ticks. It is cleared on the start edge and at each bit boundary.
- Vote: the majority of `rxs` sampled at ticks where `os_cnt` = OS/2-1, OS/2 and OS/2+1. The decision is taken at the OS/2+1 tick.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when `rxs` = 0, go to START and clear the counters.
  - START: at the vote, a result of 1 is a false start; return to IDLE with no output. A result of 0 continues: at `os_cnt` = OS-1, go to DATA with `bit_idx` = 0.
  - DATA: at each vote, shift the bit into `shreg[7]` (right shift, LSB first). At `os_cnt` = OS-1, increment `bit_idx`. After bit 7, go to STOP.
  - STOP: act at the vote; do not wait for the end of the stop bit, so back-to-back frames resync.
    - Vote 1: deliver the byte, go to IDLE.
    - Vote 0 and `shreg` ≠ 0: pulse `frame_err`, discard the byte, go to IDLE.
    - Vote 0 and `shreg` = 0: pulse `frame_err`, discard the byte, go to BREAK.
  - BREAK: stay until `rxs` = 1, then go to IDLE. A fresh start edge is required before the next frame.
- Delivery into the holding register:
  - Register empty, or `rx_valid && rx_ready` in the same cycle: load the byte; `rx_valid` = 1.
  - Register full and not being accepted: keep the old byte, drop the new one, pulse `overrun`.
- Handshake: `rx_data` is stable while `rx_valid` = 1. The consumer may hold `rx_ready` high permanently. `rx_valid` falls the cycle after acceptance unless a new byte loads that same cycle.

## Timing
- Reset values: `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `overrun` = 0, `break_det` = 0, `rx_idle` = 1. FSM in IDLE, counters at 0.
- Reset mid-frame: the partial byte is discarded, the held byte is lost, and no error pulse is generated.
- Start edge to FSM leaving IDLE: 3 clocks from the pin (2 for the synchronizer, 1 for the register).
- Pin start edge to `rx_valid` rising, at DIV = 1 and OS = 16: 156 ±2 clocks (9.5 bit times plus pipeline).
- `frame_err` and `overrun` fire in the same cycle the good byte would have loaded.
- A glitch shorter than OS/2-1 ticks never produces a byte.

## Structure
- Shared package `rs232_pkg`:
  - FSM state encoding (3-bit).
  - OS default.
  - A DIV computation function.
  - DATA_BITS = 8.
- The transmitter must take its constants from this package.
- Sub-module `rs232_baud_tick` (parameter DIV; ports `clk`, `rst`, `restart`, `tick`) is the tick generator. It is reusable by the transmitter.
- The rest is a single FSM file. Target size is about 200 lines.

## Test plan
All scenarios use `CLK_HZ` = 1_600_000, `BAUD` = 100_000, `OS` = 16, `DIV` = 1, so one bit is 16 clocks.
- Send 0xA5 with `rx_ready` = 1 → `rx_data` = 0xA5, `rx_valid` high for 1 cycle at 156 ±2 clocks after the start edge, `frame_err` = 0.
- Send 0x3C then 0x7E back-to-back, with `rx_ready` = 0 until both are complete → `rx_data` = 0x3C, a single `overrun` pulse at the 0x7E stop vote, and 0x7E is never seen.
- Send 0x55 with the stop bit driven low → one `frame_err` pulse and `rx_valid` stays 0. Then send 0x12 → `rx_data` = 0x12.
- Hold `rxd` low for 30 bit times → one `frame_err` pulse, `break_det` = 1 until `rxd` returns high, then 0x81 is received correctly.
- Apply a 6-clock low glitch, then a 1-clock inverted spike in the middle of bit 3 of 0xF0 → no byte from the glitch, and 0xF0 is received intact by majority vote.
- Assert `rst` at bit 4 of 0x99 → all outputs at reset values the next cycle. Then send 0x42 → 0x42 is received.
